// File: rtl/tl_execute_pipe.sv
// MIPS execute stage: forwarding muxes, ALU, branch target, EX/MEM register,
// plus an iterative unsigned MULTU/DIVU unit with HI/LO that stalls the front end.
module tl_execute_pipe #(
  parameter int len               = 32,
  parameter int NB_SENIAL_CONTROL = 8,
  parameter int NB_ALU_CONTROL    = 4,
  parameter int NB_REG            = 5
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_valid,
  input  logic                         i_flush,
  input  logic [len-1:0]               i_adder_if,
  input  logic [len-1:0]               i_dato1,
  input  logic [len-1:0]               i_dato2,
  input  logic [len-1:0]               i_sign_extend,
  input  logic [NB_SENIAL_CONTROL-1:0] i_senial_control,
  input  logic [NB_ALU_CONTROL-1:0]    i_alu_control,
  input  logic [NB_REG-1:0]            i_rt,
  input  logic [NB_REG-1:0]            i_rd,
  input  logic [1:0]                   i_fwd_a,
  input  logic [1:0]                   i_fwd_b,
  input  logic [len-1:0]               i_wb_data,
  input  logic [1:0]                   i_md_op,
  input  logic [1:0]                   i_md_read,
  output logic                         o_stall,
  output logic [len-1:0]               o_alu_result,
  output logic [len-1:0]               o_store_data,
  output logic [len-1:0]               o_branch_target,
  output logic                         o_PCSrc,
  output logic [NB_SENIAL_CONTROL-1:0] o_senial_control,
  output logic [NB_REG-1:0]            o_reg_dst
);
  localparam int CW = $clog2(len + 1);
  localparam logic [NB_ALU_CONTROL-1:0] ALU_AND  = 'd0;
  localparam logic [NB_ALU_CONTROL-1:0] ALU_OR   = 'd1;
  localparam logic [NB_ALU_CONTROL-1:0] ALU_ADD  = 'd2;
  localparam logic [NB_ALU_CONTROL-1:0] ALU_XOR  = 'd3;
  localparam logic [NB_ALU_CONTROL-1:0] ALU_SUB  = 'd6;
  localparam logic [NB_ALU_CONTROL-1:0] ALU_SLT  = 'd7;
  localparam logic [NB_ALU_CONTROL-1:0] ALU_SLTU = 'd8;
  localparam logic [NB_ALU_CONTROL-1:0] ALU_NOR  = 'd12;

  logic [len-1:0] op_a, op_bf, op_b, alu_res, res_mux;
  logic           zero, accept, issue;

  logic           busy, md_div;
  logic [CW-1:0]  cnt;
  logic [len-1:0] hi, lo, md_hi, md_lo, md_b, nxt_hi, nxt_lo;
  logic [len:0]   mul_sum, div_shift, div_diff;

  always_comb begin
    case (i_fwd_a)
      2'b01:   op_a = o_alu_result;
      2'b10:   op_a = i_wb_data;
      default: op_a = i_dato1;
    endcase
    case (i_fwd_b)
      2'b01:   op_bf = o_alu_result;
      2'b10:   op_bf = i_wb_data;
      default: op_bf = i_dato2;
    endcase
  end

  assign op_b = i_senial_control[6] ? i_sign_extend : op_bf;

  always_comb begin
    alu_res = '0;
    case (i_alu_control)
      ALU_AND:  alu_res = op_a & op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_SLT:  alu_res = {{(len-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu_res = {{(len-1){1'b0}}, op_a < op_b};
      ALU_NOR:  alu_res = ~(op_a | op_b);
      default:  alu_res = '0;
    endcase
  end

  assign zero    = (alu_res == '0);
  assign o_stall = busy;
  assign accept  = i_valid && !busy && !i_flush;
  assign issue   = accept && (i_md_op == 2'b01 || i_md_op == 2'b10);

  always_comb begin
    case (i_md_read)
      2'b01:   res_mux = hi;
      2'b10:   res_mux = lo;
      default: res_mux = alu_res;
    endcase
  end

  // One iteration: shift-add for MULTU (md_hi:md_lo accumulates, md_lo holds
  // remaining multiplier bits), restoring step for DIVU (md_hi = partial remainder).
  assign mul_sum   = {1'b0, md_hi} + (md_lo[0] ? {1'b0, md_b} : '0);
  assign div_shift = {md_hi, md_lo[len-1]};
  assign div_diff  = div_shift - {1'b0, md_b};

  always_comb begin
    if (md_div) begin
      if (!div_diff[len]) begin
        nxt_hi = div_diff[len-1:0];
        nxt_lo = {md_lo[len-2:0], 1'b1};
      end else begin
        nxt_hi = div_shift[len-1:0];
        nxt_lo = {md_lo[len-2:0], 1'b0};
      end
    end else begin
      nxt_hi = mul_sum[len:1];
      nxt_lo = {mul_sum[0], md_lo[len-1:1]};
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      busy   <= 1'b0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      md_hi  <= '0;
      md_lo  <= '0;
      md_b   <= '0;
      md_div <= 1'b0;
    end else if (issue) begin
      busy   <= 1'b1;
      cnt    <= CW'(len);
      md_hi  <= '0;
      md_lo  <= op_a;
      md_b   <= op_bf;
      md_div <= (i_md_op == 2'b10);
    end else if (busy) begin
      cnt   <= cnt - 1'b1;
      md_hi <= nxt_hi;
      md_lo <= nxt_lo;
      if (cnt == CW'(1)) begin
        busy <= 1'b0;
        hi   <= nxt_hi;
        lo   <= nxt_lo;
      end
    end
  end

  // Bubbles clear only control and PCSrc; data fields hold so forwarding stays stable.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_alu_result     <= '0;
      o_store_data     <= '0;
      o_branch_target  <= '0;
      o_PCSrc          <= 1'b0;
      o_senial_control <= '0;
      o_reg_dst        <= '0;
    end else if (accept) begin
      o_alu_result     <= res_mux;
      o_store_data     <= op_bf;
      o_branch_target  <= i_adder_if + (i_sign_extend << 2);
      o_PCSrc          <= i_senial_control[2] & zero;
      o_senial_control <= i_senial_control;
      o_reg_dst        <= i_senial_control[5] ? i_rd : i_rt;
    end else begin
      o_PCSrc          <= 1'b0;
      o_senial_control <= '0;
    end
  end
endmodule

// File: tb/tb_tl_execute_pipe.sv
// Directed bench for tl_execute_pipe: ALU, branch, forwarding, MULTU/DIVU, reset, flush.
module tb_tl_execute_pipe;
  logic        i_clk = 1'b0, i_reset = 1'b1, i_valid, i_flush;
  logic [31:0] i_adder_if, i_dato1, i_dato2, i_sign_extend, i_wb_data;
  logic [7:0]  i_senial_control;
  logic [3:0]  i_alu_control;
  logic [4:0]  i_rt, i_rd;
  logic [1:0]  i_fwd_a, i_fwd_b, i_md_op, i_md_read;
  logic        o_stall, o_PCSrc;
  logic [31:0] o_alu_result, o_store_data, o_branch_target;
  logic [7:0]  o_senial_control;
  logic [4:0]  o_reg_dst;

  int passed = 0, total = 0;

  tl_execute_pipe dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_flush(i_flush),
    .i_adder_if(i_adder_if), .i_dato1(i_dato1), .i_dato2(i_dato2),
    .i_sign_extend(i_sign_extend), .i_senial_control(i_senial_control),
    .i_alu_control(i_alu_control), .i_rt(i_rt), .i_rd(i_rd),
    .i_fwd_a(i_fwd_a), .i_fwd_b(i_fwd_b), .i_wb_data(i_wb_data),
    .i_md_op(i_md_op), .i_md_read(i_md_read), .o_stall(o_stall),
    .o_alu_result(o_alu_result), .o_store_data(o_store_data),
    .o_branch_target(o_branch_target), .o_PCSrc(o_PCSrc),
    .o_senial_control(o_senial_control), .o_reg_dst(o_reg_dst)
  );

  always #5 i_clk = ~i_clk;

  localparam logic [3:0] ADD = 4'd2, SUB = 4'd6;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge i_clk); #1;
  endtask

  task automatic idle();
    i_valid = 0; i_flush = 0; i_adder_if = 0; i_dato1 = 0; i_dato2 = 0;
    i_sign_extend = 0; i_wb_data = 0; i_senial_control = 0; i_alu_control = ADD;
    i_rt = 0; i_rd = 0; i_fwd_a = 0; i_fwd_b = 0; i_md_op = 0; i_md_read = 0;
  endtask

  // Issue a multiply/divide, then count stall cycles (bounded).
  task automatic md_issue(input string tag, input logic [1:0] op, input logic [31:0] a, b);
    int n;
    idle(); i_valid = 1; i_dato1 = a; i_dato2 = b; i_md_op = op;
    step();
    idle();
    n = 0;
    while (o_stall && n < 100) begin step(); n++; end
    check({tag, " stall cycles"}, n, 32);
  endtask

  task automatic md_read(input string tag, input logic [1:0] sel, input logic [31:0] exp);
    idle(); i_valid = 1; i_senial_control = 8'h01; i_md_read = sel;
    step();
    check(tag, o_alu_result, exp);
    idle();
  endtask

  initial begin
    int hi_cnt;
    idle();
    #12;
    check("reset alu_result", o_alu_result, 0);
    check("reset ctrl", {24'd0, o_senial_control}, 0);
    check("reset stall", {31'd0, o_stall}, 0);
    check("reset target", o_branch_target, 0);
    i_reset = 0;

    // ADD R-type
    i_valid = 1; i_dato1 = 5; i_dato2 = 7; i_senial_control = 8'h21;
    i_rt = 5'd2; i_rd = 5'd3;
    step();
    check("add result", o_alu_result, 12);
    check("add ctrl", {24'd0, o_senial_control}, 32'h21);
    check("add reg_dst", {27'd0, o_reg_dst}, 3);
    check("add store", o_store_data, 7);

    // forwarding: A from EX/MEM (12), B from WB (3)
    i_fwd_a = 2'b01; i_fwd_b = 2'b10; i_wb_data = 3; i_dato1 = 32'hDEAD; i_dato2 = 32'hBEEF;
    step();
    check("fwd result", o_alu_result, 15);
    check("fwd store", o_store_data, 3);

    // ADDI: AluSrc, dest = rt
    idle(); i_valid = 1; i_dato1 = 5; i_dato2 = 99; i_sign_extend = 10;
    i_senial_control = 8'h41; i_rt = 5'd7; i_rd = 5'd9;
    step();
    check("addi result", o_alu_result, 15);
    check("addi reg_dst", {27'd0, o_reg_dst}, 7);
    check("addi store", o_store_data, 99);

    // BEQ taken
    idle(); i_valid = 1; i_dato1 = 9; i_dato2 = 9; i_senial_control = 8'h04;
    i_alu_control = SUB; i_adder_if = 32'h100; i_sign_extend = 32'hFFFF_FFFE;
    step();
    check("beq target", o_branch_target, 32'hF8);
    check("beq taken", {31'd0, o_PCSrc}, 1);
    // BEQ not taken
    i_dato2 = 4;
    step();
    check("beq not taken", {31'd0, o_PCSrc}, 0);
    check("bne sub result", o_alu_result, 5);

    // taken branch again, then flush the next valid branch
    i_dato2 = 9;
    step();
    check("beq retaken", {31'd0, o_PCSrc}, 1);
    i_flush = 1;
    step();
    check("flush pcsrc", {31'd0, o_PCSrc}, 0);
    check("flush ctrl", {24'd0, o_senial_control}, 0);

    // flush together with MULTU issue: no issue
    idle(); i_valid = 1; i_flush = 1; i_md_op = 2'b01; i_dato1 = 3; i_dato2 = 4;
    step();
    check("flush+issue stall", {31'd0, o_stall}, 0);
    idle();

    // MULTU 0xFFFFFFFF * 2 with a valid ADD held during the stall
    i_valid = 1; i_dato1 = 32'hFFFF_FFFF; i_dato2 = 2; i_md_op = 2'b01;
    step();
    hi_cnt = o_stall ? 1 : 0;
    idle(); i_valid = 1; i_senial_control = 8'h21; i_md_op = 2'b01; i_dato1 = 1; i_dato2 = 1;
    for (int k = 0; k < 40 && o_stall; k++) begin
      step();
      if (o_stall) hi_cnt++;
      check("mult bubble ctrl", {24'd0, o_senial_control}, 0);
    end
    idle();
    check("mult stall cycles", hi_cnt, 32);
    md_read("mfhi mult", 2'b01, 32'h1);
    md_read("mflo mult", 2'b10, 32'hFFFF_FFFE);
    check("no reissue stall", {31'd0, o_stall}, 0);

    // DIVU
    md_issue("divu 100/7", 2'b10, 100, 7);
    md_read("mflo div", 2'b10, 14);
    md_read("mfhi div", 2'b01, 2);
    md_issue("divu 100/0", 2'b10, 100, 0);
    md_read("mflo div0", 2'b10, 32'hFFFF_FFFF);
    md_read("mfhi div0", 2'b01, 100);

    // reset in the middle of a DIVU
    idle(); i_valid = 1; i_dato1 = 100; i_dato2 = 7; i_md_op = 2'b10; i_senial_control = 8'h01;
    step();
    idle();
    for (int k = 0; k < 10; k++) step();
    check("pre-reset stall", {31'd0, o_stall}, 1);
    i_reset = 1; #2;
    check("rst stall", {31'd0, o_stall}, 0);
    check("rst alu_result", o_alu_result, 0);
    check("rst store", o_store_data, 0);
    check("rst ctrl", {24'd0, o_senial_control}, 0);
    check("rst reg_dst", {27'd0, o_reg_dst}, 0);
    #2; i_reset = 0;
    md_read("rst hi", 2'b01, 0);
    md_read("rst lo", 2'b10, 0);
    check("rst no stall", {31'd0, o_stall}, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
